// File: rtl/flash_read_arbiter_if.sv
// rtl/flash_read_arbiter_if.sv - requester, flash and response signals of the flash read arbiter
interface flash_read_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int LEN_W   = 3,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*32-1:0]    req_addr;
    logic [NUM_REQ*LEN_W-1:0] req_len;

    logic                     flash_ren;
    logic [31:0]              flash_addr;
    logic [63:0]              flash_data;

    logic                     resp_valid;
    logic                     resp_ready;
    logic [63:0]              resp_data;
    logic [ID_W-1:0]          resp_id;
    logic                     resp_last;
    logic                     resp_err;

    // Arbiter side.
    modport master (
        input  req_valid, req_addr, req_len, flash_data, resp_ready,
        output req_ready, flash_ren, flash_addr,
        output resp_valid, resp_data, resp_id, resp_last, resp_err
    );

    // Requesters, flash helper and response consumer side.
    modport slave (
        output req_valid, req_addr, req_len, flash_data, resp_ready,
        input  req_ready, flash_ren, flash_addr,
        input  resp_valid, resp_data, resp_id, resp_last, resp_err
    );
endinterface

// File: rtl/flash_read_arbiter.sv
// rtl/flash_read_arbiter.sv - round-robin burst read arbiter for one flash read port; range check under FLASH_ARB_RANGE_CHECK_EN
module flash_read_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int LEN_W      = 3,
    parameter int FLASH_SIZE = 8192,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    flash_read_arbiter_if.master  bus
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (FLASH_SIZE < 8 || (FLASH_SIZE % 8) != 0) begin : g_bad_flash_size
        $error("FLASH_SIZE must be a non-zero multiple of 8");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state, next_state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id_q;
    logic [31:0]       cur_addr;
    logic [LEN_W-1:0]  beats_left;

    logic [NUM_REQ-1:0] rot;
    logic               found;
    logic [ID_W-1:0]    winner;
    logic [31:0]        sel_addr;
    logic [LEN_W-1:0]   sel_len;
    logic               beat_err;
    logic               last_beat;

    assign last_beat = (beats_left == '0);

    // Rotate so bit 0 is the rr pointer's requester; the first set bit wins.
    always_comb begin
        rot    = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr);
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found  = 1'b1;
                winner = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_addr = bus.req_addr[i*32 +: 32];
                sel_len  = bus.req_len[i*LEN_W +: LEN_W];
            end
        end
    end

`ifdef FLASH_ARB_RANGE_CHECK_EN
    assign beat_err = ({1'b0, cur_addr} + 33'd8) > 33'(FLASH_SIZE);
`else
    assign beat_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (found) next_state = S_READ;
            S_READ: next_state = S_RESP;
            S_RESP: if (bus.resp_ready) next_state = last_beat ? S_IDLE : S_READ;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = '0;
        bus.flash_ren  = 1'b0;
        bus.flash_addr = '0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        bus.resp_id    = '0;
        bus.resp_last  = 1'b0;
        bus.resp_err   = 1'b0;
        case (state)
            S_IDLE: if (found && !reset) bus.req_ready = NUM_REQ'(1) << winner;
            S_READ: begin
                // An out-of-range beat still spends its read cycle, just without touching flash.
                bus.flash_ren  = !beat_err;
                bus.flash_addr = cur_addr;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = beat_err ? 64'd0 : bus.flash_data;
                bus.resp_id    = id_q;
                bus.resp_last  = last_beat;
                bus.resp_err   = beat_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            id_q       <= '0;
            cur_addr   <= '0;
            beats_left <= '0;
        end else begin
            if (state == S_IDLE && found) begin
                id_q       <= winner;
                cur_addr   <= sel_addr & ~32'h7;
                beats_left <= sel_len;
            end else if (state == S_RESP && bus.resp_ready) begin
                if (last_beat) begin
                    rr_ptr <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                end else begin
                    cur_addr   <= cur_addr + 32'd8;
                    beats_left <= beats_left - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb/tb_flash_read_arbiter.sv - directed bench with a burst-level reference model for flash_read_arbiter
`timescale 1ns/1ps
module tb_flash_read_arbiter;
    localparam int NUM_REQ    = 2;
    localparam int LEN_W      = 3;
    localparam int FLASH_SIZE = 8192;
    localparam int ID_W       = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    flash_read_arbiter_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .ID_W(ID_W)) bus ();

    flash_read_arbiter #(
        .NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .FLASH_SIZE(FLASH_SIZE), .ID_W(ID_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [63:0] img(input logic [31:0] a);
        return {32'hF1A5_0000 ^ a, ~a};
    endfunction

    function automatic bit model_err(input logic [31:0] a);
`ifdef FLASH_ARB_RANGE_CHECK_EN
        return (64'(a) + 64'd8) > 64'(FLASH_SIZE);
`else
        return (a != a);
`endif
    endfunction

    // Flash helper: data appears the cycle after ren and is held otherwise.
    logic [63:0] flash_q = '0;
    always @(posedge clk) if (bus.flash_ren) flash_q <= img(bus.flash_addr);
    assign bus.flash_data = flash_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Burst-level model: an accepted burst is a list of beats at base+8*n, each costing a read then a response.
    bit          m_busy = 0, m_resp = 0;
    int          m_owner = 0, m_idx = 0, m_beats = 0, m_rr = 0;
    logic [31:0] m_base = '0;
    int          grant_log[$];
    logic [31:0] faddr_log[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] e_rdy;
        logic [31:0]        a;
        bit                 err, last;
        int                 w;
        if (reset) begin
            m_busy = 0; m_resp = 0; m_rr = 0;
            check("rst_req_ready", 64'(bus.req_ready), 64'd0);
            check("rst_flash_ren", 64'(bus.flash_ren), 64'd0);
            check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        end else begin
            e_rdy = '0;
            w = -1;
            if (!m_busy)
                for (int k = 0; k < NUM_REQ; k++)
                    if (w < 0 && bus.req_valid[(m_rr + k) % NUM_REQ]) w = (m_rr + k) % NUM_REQ;
            if (w >= 0) e_rdy[w] = 1'b1;
            a    = m_base + 32'(8 * m_idx);
            err  = model_err(a);
            last = (m_idx == m_beats - 1);
            check("req_ready", 64'(bus.req_ready), 64'(e_rdy));
            check("flash_ren", 64'(bus.flash_ren), 64'(m_busy && !m_resp && !err));
            if (m_busy && !m_resp) check("flash_addr", 64'(bus.flash_addr), 64'(a));
            check("resp_valid", 64'(bus.resp_valid), 64'(m_busy && m_resp));
            if (m_busy && m_resp) begin
                check("resp_data", bus.resp_data, err ? 64'd0 : img(a));
                check("resp_id", 64'(bus.resp_id), 64'(m_owner));
                check("resp_last", 64'(bus.resp_last), 64'(last));
                check("resp_err", 64'(bus.resp_err), 64'(err));
            end
            for (int i = 0; i < NUM_REQ; i++)
                if (bus.req_valid[i] && bus.req_ready[i]) grant_log.push_back(i);
            if (bus.flash_ren) faddr_log.push_back(bus.flash_addr);
            if (bus.resp_valid && bus.resp_ready && bus.resp_last) done_cnt++;
            if (!m_busy) begin
                if (w >= 0) begin
                    m_busy  = 1; m_resp = 0; m_owner = w; m_idx = 0;
                    m_base  = bus.req_addr[w*32 +: 32] & ~32'h7;
                    m_beats = int'(bus.req_len[w*LEN_W +: LEN_W]) + 1;
                end
            end else if (!m_resp) begin
                m_resp = 1;
            end else if (bus.resp_ready) begin
                if (last) begin
                    m_busy = 0;
                    m_rr   = (m_owner + 1) % NUM_REQ;
                end else begin
                    m_idx++;
                    m_resp = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input int len);
        bus.req_addr[i*32 +: 32]       = a;
        bus.req_len[i*LEN_W +: LEN_W]  = LEN_W'(len);
    endtask

    // Raise one request for the cycle in which the idle arbiter accepts it.
    task automatic issue(input int i, input logic [31:0] a, input int len);
        set_req(i, a, len);
        bus.req_valid[i] = 1'b1;
        step();
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_bursts(input int target, input string name);
        int cyc = 0;
        while (done_cnt < target && cyc < 300) begin step(); cyc++; end
        check(name, 64'(done_cnt >= target), 64'd1);
    endtask

    initial begin
        int base;
        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus.req_len    = '0;
        bus.resp_ready = 1'b1;

        // Outputs stay quiet under reset even with requests pending.
        bus.req_valid = 2'b11;
        repeat (2) step();
        check("reset_req_ready", 64'(bus.req_ready), 64'd0);
        check("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
        bus.req_valid = '0;
        reset = 1'b0;
        step();

        // Single beat: read at T+1, response at T+2.
        grant_log.delete(); faddr_log.delete();
        issue(0, 32'h0, 0);
        check("single_ren", 64'(bus.flash_ren), 64'd1);
        check("single_addr", 64'(bus.flash_addr), 64'h0);
        step();
        check("single_valid", 64'(bus.resp_valid), 64'd1);
        check("single_data", bus.resp_data, 64'hF1A5_0000_FFFF_FFFF);
        check("single_id", 64'(bus.resp_id), 64'd0);
        check("single_last", 64'(bus.resp_last), 64'd1);
        wait_bursts(1, "single_done");

        // Misaligned 3-beat burst from requester 1.
        grant_log.delete(); faddr_log.delete();
        issue(1, 32'h0000_000B, 2);
        wait_bursts(2, "burst_done");
        check("burst_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd1);
        check("burst_nreads", 64'(faddr_log.size()), 64'd3);
        if (faddr_log.size() == 3) begin
            check("burst_addr0", 64'(faddr_log[0]), 64'h08);
            check("burst_addr1", 64'(faddr_log[1]), 64'h10);
            check("burst_addr2", 64'(faddr_log[2]), 64'h18);
        end

        // Round robin with both requesters held valid.
        grant_log.delete(); faddr_log.delete();
        base = done_cnt;
        set_req(0, 32'h100, 0);
        set_req(1, 32'h200, 0);
        bus.req_valid = 2'b11;
        for (int c = 0; c < 100 && grant_log.size() < 4; c++) step();
        bus.req_valid = '0;
        wait_bursts(base + 4, "rr_done");
        check("rr_ngrants", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() == 4) begin
            check("rr_g0", 64'(grant_log[0]), 64'd0);
            check("rr_g1", 64'(grant_log[1]), 64'd1);
            check("rr_g2", 64'(grant_log[2]), 64'd0);
            check("rr_g3", 64'(grant_log[3]), 64'd1);
        end

        // Backpressure on the first beat of a 2-beat burst.
        grant_log.delete(); faddr_log.delete();
        base = done_cnt;
        bus.resp_ready = 1'b0;
        issue(0, 32'h40, 1);
        step();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 64'(bus.resp_valid), 64'd1);
            check("bp_data", bus.resp_data, 64'hF1A5_0040_FFFF_FFBF);
            check("bp_last", 64'(bus.resp_last), 64'd0);
            step();
        end
        check("bp_reads_held", 64'(faddr_log.size()), 64'd1);
        bus.resp_ready = 1'b1;
        wait_bursts(base + 1, "bp_done");
        check("bp_reads", 64'(faddr_log.size()), 64'd2);
        if (faddr_log.size() == 2) check("bp_addr1", 64'(faddr_log[1]), 64'h48);

        // Reset during the second beat's response of a 4-beat burst.
        grant_log.delete(); faddr_log.delete();
        base = done_cnt;
        issue(0, 32'h80, 3);
        repeat (3) step();
        check("mid_in_resp", 64'(bus.resp_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus.resp_valid), 64'd0);
        check("mid_rst_data", bus.resp_data, 64'd0);
        check("mid_rst_last", 64'(bus.resp_last), 64'd0);
        check("mid_rst_ren", 64'(bus.flash_ren), 64'd0);
        step();
        reset = 1'b0;
        grant_log.delete();
        set_req(0, 32'h300, 0);
        set_req(1, 32'h400, 0);
        bus.req_valid = 2'b11;
        step();
        bus.req_valid = '0;
        wait_bursts(base + 1, "mid_done");
        check("mid_first_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);
        check("mid_ngrants", 64'(grant_log.size()), 64'd1);

`ifdef FLASH_ARB_RANGE_CHECK_EN
        // Second beat crosses the end of flash.
        grant_log.delete(); faddr_log.delete();
        base = done_cnt;
        issue(0, 32'h1FF8, 1);
        check("rng_ren0", 64'(bus.flash_ren), 64'd1);
        check("rng_addr0", 64'(bus.flash_addr), 64'h1FF8);
        step();
        check("rng_err0", 64'(bus.resp_err), 64'd0);
        step();
        check("rng_ren1", 64'(bus.flash_ren), 64'd0);
        step();
        check("rng_err1", 64'(bus.resp_err), 64'd1);
        check("rng_data1", bus.resp_data, 64'd0);
        check("rng_last1", 64'(bus.resp_last), 64'd1);
        wait_bursts(base + 1, "rng_done");
        check("rng_reads", 64'(faddr_log.size()), 64'd1);
`endif

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
